// File: rtl/gauss_pkg.sv
// ----------------------------------------------------------------------------
// gauss_pkg
// Shared definitions for the CLT Gaussian generator: FSM state type, the
// fractional width of the SCALE multiplier and the default LFSR geometry.
// ----------------------------------------------------------------------------
package gauss_pkg;

    // SCALE is Q4.12, so 4096 represents 1.0.
    localparam int unsigned SCALE_FRAC_W = 12;

    localparam int unsigned LFSR_W_DEF    = 20;
    localparam logic [19:0] LFSR_TAPS_DEF = 20'h90000;  // x^20 + x^17 + 1

    typedef enum logic [2:0] {
        StIdle,
        StAccum,
        StScale,
        StHold,
        StDone
    } state_e;

endpackage

// File: rtl/clt_gauss_gen_if.sv
// ----------------------------------------------------------------------------
// clt_gauss_gen_if
// Control/result bundle of the CLT Gaussian generator.
//   master : processor side (drives start/target/seed/ready, reads results)
//   slave  : generator side
// Signals: start, target_cnt, seed, seed_load, out_ready (master -> slave);
//          out_data, out_valid, busy, complete, invalid, sample_cnt
//          (slave -> master).
// ----------------------------------------------------------------------------
interface clt_gauss_gen_if #(
    parameter int unsigned LFSR_W = 20,
    parameter int unsigned OUT_W  = 32,
    parameter int unsigned CNT_W  = 24
);
    logic              start;
    logic [CNT_W-1:0]  target_cnt;
    logic [LFSR_W-1:0] seed;
    logic              seed_load;
    logic [OUT_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              complete;
    logic              invalid;
    logic [CNT_W-1:0]  sample_cnt;

    modport master (
        output start, target_cnt, seed, seed_load, out_ready,
        input  out_data, out_valid, busy, complete, invalid, sample_cnt
    );

    modport slave (
        input  start, target_cnt, seed, seed_load, out_ready,
        output out_data, out_valid, busy, complete, invalid, sample_cnt
    );
endinterface

// File: rtl/lfsr_step.sv
// ----------------------------------------------------------------------------
// lfsr_step
// Fibonacci LFSR, shifting left with the XOR of the tapped bits as new LSB.
// Ports:
//   clk, nreset : clock, asynchronous active-low reset (state resets to 1)
//   i_en        : advance one step
//   i_load      : load i_seed (a zero seed loads 1); has priority over i_en
//   i_seed      : seed value
//   o_state     : current state
// ----------------------------------------------------------------------------
module lfsr_step
    import gauss_pkg::*;
#(
    parameter int unsigned       W    = LFSR_W_DEF,
    parameter logic [W-1:0]      TAPS = W'(LFSR_TAPS_DEF)
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         i_en,
    input  logic         i_load,
    input  logic [W-1:0] i_seed,
    output logic [W-1:0] o_state
);

    logic [W-1:0] r_state;
    logic         w_fb;

    assign w_fb    = ^(r_state & TAPS);
    assign o_state = r_state;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= W'(1);
        end else if (i_load) begin
            // The all-zero state is a lock-up state, never load it.
            r_state <= (i_seed == '0) ? W'(1) : i_seed;
        end else if (i_en) begin
            r_state <= {r_state[W-2:0], w_fb};
        end
    end

endmodule

// File: rtl/clt_gauss_gen.sv
// ----------------------------------------------------------------------------
// clt_gauss_gen
// Central-limit-theorem Gaussian generator. Each sample is the sum of TERMS
// consecutive LFSR states (read as uniforms in [0,1)), mean removed, scaled
// by SCALE (Q4.12) and presented as a signed OUT_W value with FRAC_W
// fraction bits through a valid/ready handshake, up to target_cnt samples.
// Ports:
//   clk, nreset : clock, asynchronous active-low reset
//   bus         : clt_gauss_gen_if.slave (control, result handshake, status)
// Optional feature macro: GAUSS_CLIP_EN -- when defined, samples whose
// magnitude exceeds CLIP_LIM are dropped with a one-cycle invalid pulse;
// when undefined, invalid is tied low and every sample is presented.
// ----------------------------------------------------------------------------
module clt_gauss_gen
    import gauss_pkg::*;
#(
    parameter int unsigned       LFSR_W    = LFSR_W_DEF,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(LFSR_TAPS_DEF),
    parameter int unsigned       TERMS     = 12,
    parameter int unsigned       SCALE     = 4096,
    parameter int unsigned       OUT_W     = 32,
    parameter int unsigned       FRAC_W    = 15,
    parameter int unsigned       CNT_W     = 24,
    parameter int unsigned       CLIP_LIM  = 32'h00020000
) (
    input  logic            clk,
    input  logic            nreset,
    clt_gauss_gen_if.slave  bus
);

    localparam int unsigned TERM_W = $clog2(TERMS);
    localparam int unsigned ACC_W  = LFSR_W + TERM_W;
    localparam int unsigned CEN_W  = ACC_W + 1;
    localparam int unsigned PROD_W = CEN_W + 33;
    localparam int unsigned SHIFT  = LFSR_W + SCALE_FRAC_W - FRAC_W;

    // Expected value of the sum: TERMS * 0.5 in LFSR_W fraction bits.
    localparam logic [CEN_W-1:0]         MEAN    = CEN_W'(TERMS) << (LFSR_W - 1);
    localparam logic signed [PROD_W-1:0] SCALE_S = PROD_W'(SCALE);

    state_e              r_state;
    logic [ACC_W-1:0]    r_acc;
    logic [TERM_W-1:0]   r_term;
    logic [CNT_W-1:0]    r_target;
    logic [CNT_W-1:0]    r_cnt;
    logic [OUT_W-1:0]    r_out;
    logic                r_valid;
    logic                r_complete;

    logic [LFSR_W-1:0]          w_lfsr;
    logic                       w_lfsr_en;
    logic                       w_lfsr_load;
    logic                       w_ctrl_ok;
    logic signed [CEN_W-1:0]    w_centered;
    logic signed [PROD_W-1:0]   w_cen_ext;
    logic signed [PROD_W-1:0]   w_prod;
    logic signed [OUT_W-1:0]    w_out;

    // start / seed_load are only honoured outside a run.
    assign w_ctrl_ok   = (r_state == StIdle) || (r_state == StDone);
    assign w_lfsr_en   = (r_state == StAccum);
    assign w_lfsr_load = bus.seed_load && w_ctrl_ok;

    lfsr_step #(
        .W    (LFSR_W),
        .TAPS (LFSR_TAPS)
    ) u_lfsr (
        .clk     (clk),
        .nreset  (nreset),
        .i_en    (w_lfsr_en),
        .i_load  (w_lfsr_load),
        .i_seed  (bus.seed),
        .o_state (w_lfsr)
    );

    assign w_centered = $signed({1'b0, r_acc} - MEAN);
    assign w_cen_ext  = PROD_W'(w_centered);
    assign w_prod     = w_cen_ext * SCALE_S;
    assign w_out      = OUT_W'(w_prod >>> SHIFT);

`ifdef GAUSS_CLIP_EN
    localparam logic signed [OUT_W:0] LIM = (OUT_W + 1)'(CLIP_LIM);

    logic                r_invalid;
    logic signed [OUT_W:0] w_out_ext;
    logic                w_clip;

    // One extra bit so negating the limit cannot overflow.
    assign w_out_ext   = (OUT_W + 1)'(w_out);
    assign w_clip      = (w_out_ext > LIM) || (w_out_ext < -LIM);
    assign bus.invalid = r_invalid;
`else
    assign bus.invalid = 1'b0;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state    <= StIdle;
            r_acc      <= '0;
            r_term     <= '0;
            r_target   <= '0;
            r_cnt      <= '0;
            r_out      <= '0;
            r_valid    <= 1'b0;
            r_complete <= 1'b0;
`ifdef GAUSS_CLIP_EN
            r_invalid  <= 1'b0;
`endif
        end else begin
`ifdef GAUSS_CLIP_EN
            r_invalid <= 1'b0;
`endif
            unique case (r_state)
                StIdle, StDone: begin
                    if (bus.start) begin
                        r_target   <= bus.target_cnt;
                        r_cnt      <= '0;
                        r_acc      <= '0;
                        r_term     <= '0;
                        if (bus.target_cnt == '0) begin
                            r_complete <= 1'b1;
                            r_state    <= StDone;
                        end else begin
                            r_complete <= 1'b0;
                            r_state    <= StAccum;
                        end
                    end
                end
                StAccum: begin
                    r_acc <= r_acc + ACC_W'(w_lfsr);
                    if (r_term == TERM_W'(TERMS - 1)) begin
                        r_term  <= '0;
                        r_state <= StScale;
                    end else begin
                        r_term <= r_term + TERM_W'(1);
                    end
                end
                StScale: begin
`ifdef GAUSS_CLIP_EN
                    if (w_clip) begin
                        // Drop the sample; the LFSR keeps running from here.
                        r_invalid <= 1'b1;
                        r_acc     <= '0;
                        r_state   <= StAccum;
                    end else begin
                        r_out   <= w_out;
                        r_valid <= 1'b1;
                        r_state <= StHold;
                    end
`else
                    r_out   <= w_out;
                    r_valid <= 1'b1;
                    r_state <= StHold;
`endif
                end
                StHold: begin
                    if (r_valid && bus.out_ready) begin
                        r_valid <= 1'b0;
                        r_cnt   <= r_cnt + CNT_W'(1);
                        r_acc   <= '0;
                        if ((r_cnt + CNT_W'(1)) == r_target) begin
                            r_complete <= 1'b1;
                            r_state    <= StDone;
                        end else begin
                            r_state <= StAccum;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.out_data   = r_out;
    assign bus.out_valid  = r_valid;
    assign bus.complete   = r_complete;
    assign bus.sample_cnt = r_cnt;
    assign bus.busy       = (r_state == StAccum) || (r_state == StScale) ||
                            (r_state == StHold);

endmodule
